// File: rtl/imem_loader_if.sv
`default_nettype none
// imem_loader_if: framed byte-stream input, instruction-memory write port and load status.
// Rev 1.0
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              load_req;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              err;
    logic [6:0]        word_count;

    modport master (
        output load_req, byte_in, byte_valid,
        input  byte_ready, mem_we, mem_addr, mem_din, cpu_rst, busy, done, err, word_count
    );

    modport slave (
        input  load_req, byte_in, byte_valid,
        output byte_ready, mem_we, mem_addr, mem_din, cpu_rst, busy, done, err, word_count
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// imem_loader: assembles a LEN/DATA/CSUM byte frame into 32-bit words for instruction memory.
// Rev 1.0
module imem_loader #(
    parameter int ADDR_W        = 8,
    parameter int MAX_WORDS     = 64,
    parameter bit HOLD_ON_RESET = 1'b1
) (
    input wire           CLK,
    input wire           RST,
    imem_loader_if.slave bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_CSUM  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [31:0]       word_q, word_d;
    logic [1:0]        idx_q, idx_d;
    logic [7:0]        xor_q, xor_d;
    logic [6:0]        n_q, n_d;
    logic [6:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              mem_we_q, mem_we_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic ready;
    logic accept;
    logic len_bad;
    logic last_word;
    logic csum_ok;

    assign ready     = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
    assign accept    = bus.byte_valid && ready;
    assign len_bad   = (bus.byte_in == 8'd0) || ({24'd0, bus.byte_in} > 32'(MAX_WORDS));
    assign last_word = ((cnt_q + 7'd1) == n_q);
    assign csum_ok   = (bus.byte_in == xor_q);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.load_req) state_d = S_LEN;
            end
            S_LEN: begin
                if (accept) state_d = len_bad ? S_ERR : S_DATA;
            end
            S_DATA: begin
                if (accept && (idx_q == 2'd3)) state_d = S_WRITE;
            end
            S_WRITE: begin
                state_d = last_word ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                if (accept) state_d = csum_ok ? S_DONE : S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        word_d    = word_q;
        idx_d     = idx_q;
        xor_d     = xor_q;
        n_d       = n_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        cpu_rst_d = cpu_rst_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.load_req) begin
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    cnt_d     = 7'd0;
                    xor_d     = 8'd0;
                    idx_d     = 2'd0;
                    addr_d    = '0;
                    cpu_rst_d = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            S_LEN: begin
                if (accept) begin
                    if (len_bad) begin
                        err_d  = 1'b1;
                        busy_d = 1'b0;
                    end else begin
                        n_d = bus.byte_in[6:0];
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    // Little-endian lane placement: first byte of a word lands in [7:0].
                    word_d[{idx_q, 3'b000} +: 8] = bus.byte_in;
                    xor_d = xor_q ^ bus.byte_in;
                    idx_d = idx_q + 2'd1;
                end
            end
            S_WRITE: begin
                addr_d = addr_q + ADDR_W'(4);
                cnt_d  = cnt_q + 7'd1;
                idx_d  = 2'd0;
            end
            S_CSUM: begin
                if (accept) begin
                    busy_d = 1'b0;
                    if (csum_ok) begin
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
        // Write strobe comes straight from a flop so it is glitch-free at the memory.
        mem_we_d = (state_d == S_WRITE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            word_q    <= 32'd0;
            idx_q     <= 2'd0;
            xor_q     <= 8'd0;
            n_q       <= 7'd0;
            cnt_q     <= 7'd0;
            addr_q    <= '0;
            mem_we_q  <= 1'b0;
            cpu_rst_q <= HOLD_ON_RESET;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            word_q    <= word_d;
            idx_q     <= idx_d;
            xor_q     <= xor_d;
            n_q       <= n_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            mem_we_q  <= mem_we_d;
            cpu_rst_q <= cpu_rst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.byte_ready = ready;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_din    = word_q;
    assign bus.cpu_rst    = cpu_rst_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.word_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// tb_imem_loader: directed frames checked against a frame-level model of the loader.
// Rev 1.0
module tb_imem_loader;
    localparam int ADDR_W    = 8;
    localparam int MAX_WORDS = 64;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(
        .ADDR_W(ADDR_W),
        .MAX_WORDS(MAX_WORDS),
        .HOLD_ON_RESET(1'b1)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    logic [7:0]        frame [0:300];
    int                flen;
    logic [ADDR_W-1:0] exp_addr [$];
    logic [31:0]       exp_data [$];
    int                wr_seen = 0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic [31:0]       last_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Every write pulse must match the next expected (addr, data) pair from the model.
    always @(negedge CLK) begin
        if (!RST && bus.mem_we === 1'b1) begin
            chk("ready_low_in_write", 32'(bus.byte_ready), 32'd0);
            if (exp_addr.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                         bus.mem_addr, bus.mem_din);
            end else begin
                chk("wr_addr", 32'(bus.mem_addr), 32'(exp_addr.pop_front()));
                chk("wr_data", bus.mem_din, exp_data.pop_front());
            end
            wr_seen++;
            last_addr = bus.mem_addr;
            last_data = bus.mem_din;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap, input bit lr);
        bit got;
        got = 1'b0;
        bus.byte_valid = 1'b0;
        repeat (gap) begin
            @(posedge CLK);
            #1;
        end
        bus.byte_valid = 1'b1;
        bus.byte_in    = b;
        bus.load_req   = lr;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge CLK);
            got = bus.byte_ready;
            @(posedge CLK);
            #1;
            bus.load_req = 1'b0;
        end
        bus.byte_valid = 1'b0;
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL byte_timeout: byte 0x%0h not accepted, expected acceptance within 40 cycles", b);
        end
    endtask

    task automatic start_load(input bit with_byte);
        @(posedge CLK);
        #1;
        bus.load_req = 1'b1;
        if (with_byte) begin
            bus.byte_valid = 1'b1;
            bus.byte_in    = frame[0];
        end
        @(posedge CLK);
        #1;
        bus.load_req = 1'b0;
    endtask

    // Model: derive the expected writes and the final flags from the frame contents alone.
    task automatic run_frame(input int gapmax, input bit with_byte, input int lr_at);
        int         n;
        bit         legal;
        bit         ok;
        logic [7:0] x;
        n     = int'(frame[0]);
        legal = (n >= 1) && (n <= MAX_WORDS);
        x     = 8'd0;
        ok    = 1'b0;
        if (legal) begin
            for (int w = 0; w < n; w++) begin
                exp_addr.push_back(ADDR_W'(4 * w));
                exp_data.push_back({frame[4*w+4], frame[4*w+3], frame[4*w+2], frame[4*w+1]});
                for (int k = 1; k <= 4; k++) x = x ^ frame[4*w+k];
            end
            ok = (frame[4*n+1] == x);
        end
        wr_seen = 0;
        start_load(with_byte);
        for (int i = 0; i < flen; i++)
            send_byte(frame[i], (gapmax == 0) ? 0 : int'($urandom_range(0, gapmax)), i == lr_at);
        @(negedge CLK);
        chk("done",        32'(bus.done),       32'(ok));
        chk("err",         32'(bus.err),        32'(!ok));
        chk("cpu_rst",     32'(bus.cpu_rst),    32'(!ok));
        chk("busy",        32'(bus.busy),       32'd0);
        chk("word_count",  32'(bus.word_count), legal ? 32'(n) : 32'd0);
        chk("writes_seen", 32'(wr_seen),        legal ? 32'(n) : 32'd0);
        chk("writes_left", 32'(exp_addr.size()), 32'd0);
    endtask

    task automatic set_two_word(input logic [7:0] csum);
        frame[0] = 8'd2;
        frame[1] = 8'h78; frame[2] = 8'h56; frame[3] = 8'h34; frame[4] = 8'h12;
        frame[5] = 8'hEF; frame[6] = 8'hBE; frame[7] = 8'hAD; frame[8] = 8'hDE;
        frame[9] = csum;
        flen     = 10;
    endtask

    task automatic check_reset_values();
        chk("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
        chk("rst_mem_we",     32'(bus.mem_we),     32'd0);
        chk("rst_mem_addr",   32'(bus.mem_addr),   32'd0);
        chk("rst_mem_din",    bus.mem_din,         32'd0);
        chk("rst_busy",       32'(bus.busy),       32'd0);
        chk("rst_done",       32'(bus.done),       32'd0);
        chk("rst_err",        32'(bus.err),        32'd0);
        chk("rst_word_count", 32'(bus.word_count), 32'd0);
        chk("rst_cpu_rst",    32'(bus.cpu_rst),    32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000 ns, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] x;
        bus.load_req   = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'd0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_reset_values();
        RST = 1'b0;

        // XOR of 78 56 34 12 EF BE AD DE is 0x2A.
        set_two_word(8'h2A);
        run_frame(0, 1'b0, -1);
        chk("pin_last_addr", 32'(last_addr), 32'h04);
        chk("pin_last_data", last_data,      32'hDEADBEEF);

        set_two_word(8'h2B);
        run_frame(0, 1'b0, -1);

        frame[0] = 8'd0;  flen = 1;
        run_frame(0, 1'b0, -1);
        frame[0] = 8'd65; flen = 1;
        run_frame(0, 1'b0, -1);

        frame[0] = 8'd64;
        x = 8'd0;
        for (int j = 0; j < 256; j++) begin
            frame[1+j] = 8'(j * 37 + 5);
            x = x ^ frame[1+j];
        end
        frame[257] = x;
        flen = 258;
        run_frame(3, 1'b0, -1);
        chk("pin_last_addr_64", 32'(last_addr), 32'hFC);

        // Abort mid-word with RST, then load a fresh one-word frame.
        start_load(1'b0);
        send_byte(8'd1,   0, 1'b0);
        send_byte(8'hAA,  0, 1'b0);
        send_byte(8'hBB,  0, 1'b0);
        RST = 1'b1;
        #1;
        check_reset_values();
        @(negedge CLK);
        RST = 1'b0;
        frame[0] = 8'd1;
        frame[1] = 8'h11; frame[2] = 8'h22; frame[3] = 8'h33; frame[4] = 8'h44;
        frame[5] = 8'h44;
        flen     = 6;
        run_frame(0, 1'b0, -1);
        chk("pin_abort_addr", 32'(last_addr), 32'h00);
        chk("pin_abort_data", last_data,      32'h44332211);

        set_two_word(8'h2A);
        run_frame(1, 1'b0, 3);

        // load_req together with byte_valid in DONE: that byte becomes LEN next cycle.
        frame[0] = 8'd1;
        frame[1] = 8'hAA; frame[2] = 8'hBB; frame[3] = 8'hCC; frame[4] = 8'hDD;
        frame[5] = 8'h00;
        flen     = 6;
        run_frame(0, 1'b1, -1);
        chk("pin_same_cycle_data", last_data, 32'hDDCCBBAA);

        repeat (2) @(posedge CLK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
